// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_pkg
// Description : Shared encodings for the tile grid renderer: click states,
//               tile colour codes, renderer FSM states and default colours.
// Revision    : 1.0 - initial release
// ============================================================================
package tile_pkg;

  // Click state as reported by the game controller; 3 behaves like PAUSE
  localparam logic [1:0] CLICK_PAUSE = 2'd0;
  localparam logic [1:0] CLICK_SCORE = 2'd1;
  localparam logic [1:0] CLICK_MISS  = 2'd2;

  // Colour code of one tile; also what is remembered per tile for dirty mode
  typedef enum logic [1:0] {
    CODE_BG   = 2'd0,
    CODE_TILE = 2'd1,
    CODE_HIT  = 2'd2,
    CODE_MISS = 2'd3
  } code_e;

  // Renderer state machine
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_DRAW  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Default palette
  localparam logic [8:0] DEF_BG_COLOR   = 9'h05a;
  localparam logic [8:0] DEF_TILE_COLOR = 9'h1ff;
  localparam logic [8:0] DEF_HIT_COLOR  = 9'h3f2;
  localparam logic [8:0] DEF_MISS_COLOR = 9'h3a1;

  // Colour code of a tile: only occupied tiles in the hit row show click feedback
  function automatic code_e tile_code(input logic occupied, input logic hit_row,
                                      input logic [1:0] click);
    code_e c;
    c = CODE_BG;
    if (occupied) begin
      c = CODE_TILE;
      if (hit_row && click == CLICK_SCORE) c = CODE_HIT;
      if (hit_row && click == CLICK_MISS)  c = CODE_MISS;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_pixel_scan.sv
`default_nettype none
// ============================================================================
// Module      : tile_pixel_scan
// Description : Raster counter across one TILE_W x TILE_H tile. px runs
//               fastest; last flags the bottom-right pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_pixel_scan #(
  parameter int TILE_W = 40,
  parameter int TILE_H = 30,
  parameter int PX_W   = 6,
  parameter int PY_W   = 5
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            last
);

  logic px_wrap;
  logic py_wrap;

  assign px_wrap = (px == PX_W'(TILE_W - 1));
  assign py_wrap = (py == PY_W'(TILE_H - 1));
  assign last    = px_wrap && py_wrap;

  // Step through the tile in raster order; clear has priority over enable
  always_ff @(posedge CLOCK_50) begin
    if (!reset || clear) begin
      px <= '0;
      py <= '0;
    end else if (enable) begin
      if (px_wrap) begin
        px <= '0;
        py <= py_wrap ? '0 : py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tile_grid_renderer
// Description : Snapshots a ROWS x COLS occupancy grid on start and paints
//               each tile as a TILE_W x TILE_H rectangle on the VGA pixel
//               port, one pixel per clock, optionally skipping tiles whose
//               colour is unchanged since the previous frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_grid_renderer
  import tile_pkg::*;
#(
  parameter int COLS    = 4,
  parameter int ROWS    = 4,
  parameter int TILE_W  = 40,
  parameter int TILE_H  = 30,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 9,
  parameter logic [COLOR_W-1:0] BG_COLOR   = COLOR_W'(DEF_BG_COLOR),
  parameter logic [COLOR_W-1:0] TILE_COLOR = COLOR_W'(DEF_TILE_COLOR),
  parameter logic [COLOR_W-1:0] HIT_COLOR  = COLOR_W'(DEF_HIT_COLOR),
  parameter logic [COLOR_W-1:0] MISS_COLOR = COLOR_W'(DEF_MISS_COLOR)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 dirty_only,
  input  logic [ROWS*COLS-1:0] grid,
  input  logic [1:0]           click_state,
  output logic                 busy,
  output logic                 done,
  output logic                 plot,
  output logic [X_W-1:0]       VGA_X,
  output logic [Y_W-1:0]       VGA_Y,
  output logic [COLOR_W-1:0]   VGA_COLOR
);

  localparam int NT    = ROWS * COLS;
  localparam int IDX_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PX_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PY_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  // The playfield must fit the VGA coordinate space
  if (COLS * TILE_W > (1 << X_W)) begin : g_x_range_err
    $error("tile_grid_renderer: COLS*TILE_W exceeds the VGA_X range");
  end
  if (ROWS * TILE_H > (1 << Y_W)) begin : g_y_range_err
    $error("tile_grid_renderer: ROWS*TILE_H exceeds the VGA_Y range");
  end

  state_e           state;
  logic [NT-1:0]    grid_q;
  logic [1:0]       click_q;
  logic             dirty_q;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  code_e            cur_code;
  code_e            drawn_code [NT];
  logic             drawn_valid;
  logic             tile_end;     // pixel currently on the port is the tile's last

  logic [PX_W-1:0]  px;
  logic [PY_W-1:0]  py;
  logic             scan_last;
  logic             scan_clear;
  logic             scan_enable;

  logic [IDX_W-1:0] tile_idx;
  logic [31:0]      x_full;
  logic [31:0]      y_full;
  logic             hit_row;
  logic             last_tile;
  code_e            setup_code;

  // The scanner points at the next pixel to put on the port; it leads the
  // registered outputs by one pixel so the first pixel leaves on the SETUP edge.
  assign scan_clear  = (state == ST_IDLE) || (state == ST_NEXT) || (state == ST_DONE);
  assign scan_enable = (state == ST_SETUP) || ((state == ST_DRAW) && !tile_end);

  tile_pixel_scan #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .PX_W   (PX_W),
    .PY_W   (PY_W)
  ) u_scan (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (scan_clear),
    .enable   (scan_enable),
    .px       (px),
    .py       (py),
    .last     (scan_last)
  );

  assign tile_idx   = IDX_W'(32'(row) * 32'(COLS) + 32'(col));
  assign x_full     = 32'(col) * 32'(TILE_W) + 32'(px);
  assign y_full     = 32'(row) * 32'(TILE_H) + 32'(py);
  assign hit_row    = (32'(row) == 32'(ROWS - 1));
  assign last_tile  = hit_row && (32'(col) == 32'(COLS - 1));
  assign setup_code = tile_code(grid_q[tile_idx], hit_row, click_q);

  function automatic logic [COLOR_W-1:0] code_color(input code_e c);
    logic [COLOR_W-1:0] color;
    case (c)
      CODE_TILE: color = TILE_COLOR;
      CODE_HIT:  color = HIT_COLOR;
      CODE_MISS: color = MISS_COLOR;
      default:   color = BG_COLOR;
    endcase
    return color;
  endfunction

  // Frame sequencer with registered pixel-port and handshake outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      plot        <= 1'b0;
      VGA_X       <= '0;
      VGA_Y       <= '0;
      VGA_COLOR   <= BG_COLOR;
      grid_q      <= '0;
      click_q     <= CLICK_PAUSE;
      dirty_q     <= 1'b0;
      row         <= '0;
      col         <= '0;
      cur_code    <= CODE_BG;
      drawn_valid <= 1'b0;
      tile_end    <= 1'b0;
      for (int i = 0; i < NT; i++) drawn_code[i] <= CODE_BG;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            grid_q  <= grid;
            click_q <= click_state;
            dirty_q <= dirty_only;
            row     <= '0;
            col     <= '0;
            busy    <= 1'b1;
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          cur_code <= setup_code;
          if (dirty_q && drawn_valid && (setup_code == drawn_code[tile_idx])) begin
            state <= ST_NEXT;
          end else begin
            plot      <= 1'b1;
            VGA_X     <= X_W'(x_full);
            VGA_Y     <= Y_W'(y_full);
            VGA_COLOR <= code_color(setup_code);
            tile_end  <= scan_last;
            state     <= ST_DRAW;
          end
        end

        ST_DRAW: begin
          if (tile_end) begin
            plot                 <= 1'b0;
            tile_end             <= 1'b0;
            drawn_code[tile_idx] <= cur_code;
            state                <= ST_NEXT;
          end else begin
            VGA_X    <= X_W'(x_full);
            VGA_Y    <= Y_W'(y_full);
            tile_end <= scan_last;
          end
        end

        ST_NEXT: begin
          if (last_tile) begin
            drawn_valid <= 1'b1;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            if (32'(col) == 32'(COLS - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            state <= ST_SETUP;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_grid_renderer
// Description : Directed bench for tile_grid_renderer with a pixel scoreboard
//               fed by a reference model of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_grid_renderer;

  logic        CLOCK_50;
  logic        reset;
  logic        start;
  logic        dirty_only;
  logic [15:0] grid;
  logic [1:0]  click_state;
  logic        busy;
  logic        done;
  logic        plot;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [8:0]  VGA_COLOR;

  int passed = 0;
  int total  = 0;
  int plot_count = 0;

  logic [23:0] exp_q [$];
  logic [1:0]  mcode [16];
  logic        mvalid = 1'b0;

  tile_grid_renderer #(
    .COLS   (4),
    .ROWS   (4),
    .TILE_W (4),
    .TILE_H (2)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .dirty_only  (dirty_only),
    .grid        (grid),
    .click_state (click_state),
    .busy        (busy),
    .done        (done),
    .plot        (plot),
    .VGA_X       (VGA_X),
    .VGA_Y       (VGA_Y),
    .VGA_COLOR   (VGA_COLOR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] model_code(input logic [15:0] g, input int r, input int c,
                                            input logic [1:0] cs);
    if (!g[r*4+c]) return 2'd0;
    if (r != 3)    return 2'd1;
    if (cs == 2'd1) return 2'd2;
    if (cs == 2'd2) return 2'd3;
    return 2'd1;
  endfunction

  function automatic logic [8:0] model_color(input logic [1:0] code);
    case (code)
      2'd1:    return 9'h1ff;
      2'd2:    return 9'h3f2;
      2'd3:    return 9'h3a1;
      default: return 9'h05a;
    endcase
  endfunction

  // Predict one frame: queue its pixels, return cycles to done and pixel count
  task automatic model_frame(input logic [15:0] g, input logic [1:0] cs, input logic d,
                             output int len, output int npix);
    logic [1:0] code;
    len  = 1;
    npix = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        code = model_code(g, r, c, cs);
        if (d && mvalid && mcode[r*4+c] == code) begin
          len += 2;
        end else begin
          len += 10;
          for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
              exp_q.push_back({8'(c*4+x), 7'(r*2+y), model_color(code)});
              npix++;
            end
          mcode[r*4+c] = code;
        end
      end
    end
    mvalid = 1'b1;
  endtask

  // Pixel monitor: every plotted pixel must match the head of the scoreboard
  always @(negedge CLOCK_50) begin
    if (reset && plot) begin
      plot_count++;
      if (exp_q.size() == 0) check("plot_unexpected", 32'd1, 32'd0);
      else check("pixel", {8'h0, VGA_X, VGA_Y, VGA_COLOR}, {8'h0, exp_q.pop_front()});
    end
  end

  task automatic run_frame(input logic [15:0] g, input logic [1:0] cs, input logic d,
                           input int inject);
    int len, npix, n;
    logic busy_ok, seen;
    @(negedge CLOCK_50);
    grid = g; click_state = cs; dirty_only = d; start = 1'b1;
    plot_count = 0;
    model_frame(g, cs, d, len, npix);
    n = 0; busy_ok = 1'b1; seen = 1'b0;
    while (n < 400 && !seen) begin
      @(negedge CLOCK_50);
      n++;
      if (n == 1) start = 1'b0;
      if (inject != 0 && n == inject)     begin start = 1'b1; grid = ~g; end
      if (inject != 0 && n == inject + 1) start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done)  seen = 1'b1;
    end
    check("done_latency", n, len);
    check("busy_during_frame", {31'h0, busy_ok}, 32'd1);
    check("plot_count", plot_count, npix);
    check("scoreboard_empty", exp_q.size(), 0);
    @(negedge CLOCK_50);
    check("done_pulse_width", {31'h0, done}, 32'd0);
    check("busy_after_done", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int k, n, dummy_len, dummy_pix, saw_done, idle_plots;
    reset = 1'b0; start = 1'b0; dirty_only = 1'b0; grid = '0; click_state = 2'd0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_busy",  {31'h0, busy}, 32'd0);
    check("rst_done",  {31'h0, done}, 32'd0);
    check("rst_plot",  {31'h0, plot}, 32'd0);
    check("rst_x",     {24'h0, VGA_X}, 32'd0);
    check("rst_y",     {25'h0, VGA_Y}, 32'd0);
    check("rst_color", {23'h0, VGA_COLOR}, 32'h05a);
    reset = 1'b1;

    // Single tile in the top-left corner, full frame
    run_frame(16'h0001, 2'd0, 1'b0, 0);
    // Hit-row tile under the three click feedback states
    run_frame(16'h8000, 2'd2, 1'b0, 0);
    run_frame(16'h8000, 2'd1, 1'b0, 0);
    run_frame(16'h8000, 2'd3, 1'b0, 0);
    // Full frame then an unchanged dirty frame that plots nothing
    run_frame(16'h00f0, 2'd0, 1'b0, 0);
    run_frame(16'h00f0, 2'd0, 1'b1, 0);
    // Only tile (1,1) changes
    run_frame(16'h00d0, 2'd0, 1'b1, 0);
    check("dirty_one_tile_plots", plot_count, 8);

    // Abort a frame with reset at the 50th pixel
    @(negedge CLOCK_50);
    grid = 16'h00d0; click_state = 2'd0; dirty_only = 1'b0; start = 1'b1;
    model_frame(16'h00d0, 2'd0, 1'b0, dummy_len, dummy_pix);
    k = 0; n = 0;
    while (k < 50 && n < 400) begin
      @(negedge CLOCK_50);
      n++;
      if (n == 1) start = 1'b0;
      if (plot) k++;
    end
    check("abort_reached_50", k, 50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("abort_busy",  {31'h0, busy}, 32'd0);
    check("abort_plot",  {31'h0, plot}, 32'd0);
    check("abort_done",  {31'h0, done}, 32'd0);
    check("abort_color", {23'h0, VGA_COLOR}, 32'h05a);
    check("abort_xy",    {17'h0, VGA_X, VGA_Y}, 32'd0);
    exp_q.delete();
    mvalid = 1'b0;
    reset = 1'b1;
    saw_done = 0; idle_plots = 0;
    repeat (200) begin
      @(negedge CLOCK_50);
      if (done) saw_done++;
      if (plot) idle_plots++;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_no_plot", idle_plots, 0);
    // Dirty request after reset must still redraw everything
    run_frame(16'h00d0, 2'd0, 1'b1, 0);
    check("post_reset_full_redraw", plot_count, 128);

    // Start pulse and grid change in the middle of a DRAW phase are ignored
    run_frame(16'h9234, 2'd1, 1'b0, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_grid_renderer.md
# tile_grid_renderer

Parametrised playfield renderer for the piano-tiles game. On each `start` pulse it snapshots a ROWS×COLS tile-occupancy grid and the current click state, then writes every tile as a TILE_W×TILE_H rectangle of pixels to the VGA pixel port, one pixel per clock. An optional dirty-only mode skips tiles whose drawn colour has not changed since the last frame. It replaces the fixed 4-row spawn/shift chain and is driven by the game controller (start/done handshake) into the VGA adapter (plot/X/Y/colour).

## Interface
- COLS, 4, number of tile columns
- ROWS, 4, number of tile rows; row ROWS-1 is the hit row
- TILE_W, 40, tile width in pixels
- TILE_H, 30, tile height in pixels
- X_W, 8, VGA_X width
- Y_W, 7, VGA_Y width
- COLOR_W, 9, colour width
- BG_COLOR, 9'h05a, empty tile colour
- TILE_COLOR, 9'h1ff, occupied tile colour
- HIT_COLOR, 9'h3f2, occupied hit-row tile when click_state is SCORE
- MISS_COLOR, 9'h3a1, occupied hit-row tile when click_state is MISS

Ports:
- CLOCK_50  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  frame request; sampled only in IDLE
- dirty_only  in  1  1 = skip unchanged tiles; sampled with start
- grid  in  ROWS*COLS  occupancy; bit r*COLS+c = row r, column c; sampled with start
- click_state  in  2  0 PAUSE, 1 SCORE, 2 MISS, 3 treated as PAUSE; sampled with start
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse at frame end
- plot  out  1  pixel valid
- VGA_X  out  X_W  pixel x
- VGA_Y  out  Y_W  pixel y
- VGA_COLOR  out  COLOR_W  pixel colour

## Operation
- States: IDLE, SETUP, DRAW, NEXT, DONE.
- IDLE: if start is high, latch grid, click_state and dirty_only; set row=0, col=0; go to SETUP. A start pulse outside IDLE is ignored (no queueing).
- SETUP (1 cycle): compute the tile colour code: 0 BG, 1 TILE, 2 HIT, 3 MISS. HIT and MISS apply only to row ROWS-1 with the bit set. If dirty_only=1, drawn_valid=1 and the code equals drawn_code[tile], go to NEXT. Otherwise clear px and py and go to DRAW.
- DRAW: each cycle drive plot=1, VGA_X=col*TILE_W+px, VGA_Y=row*TILE_H+py, and the colour for the code.
  - Scan is raster within the tile: px increments; at px=TILE_W-1 it wraps to 0 and py increments.
  - The pixel at (TILE_W-1, TILE_H-1) is the last one. On that cycle write drawn_code[tile] and go to NEXT.
- NEXT: advance col; wrap col at COLS-1 and increment row. If the finished tile was (ROWS-1, COLS-1), set drawn_valid=1 and go to DONE; otherwise go to SETUP.
- DONE: done=1 for one cycle, then IDLE.
- drawn_valid=0 after reset, so the first frame after reset is always a full redraw regardless of dirty_only.
- Width rule: COLS*TILE_W ≤ 2^X_W and ROWS*TILE_H ≤ 2^Y_W, checked by an elaboration-time assertion. Coordinates are computed at full width, then truncated.

## Timing
- Reset values: busy=0, done=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=BG_COLOR, state=IDLE, drawn_valid=0.
- All outputs are registered. plot, VGA_X, VGA_Y and VGA_COLOR change together.
- start high at edge k: SETUP at k+1, first plot at k+2.
- A drawn tile costs TILE_W*TILE_H+2 cycles; a skipped tile costs 2.
- Full frame: done is high in cycle k+1+ROWS*COLS*(TILE_W*TILE_H+2).
- start high during DONE is ignored; start may be accepted on the cycle after DONE.
- grid and click_state changes while busy have no effect on the current frame.
- Reset mid-frame: abort on the next edge, all outputs go to reset values, drawn_valid is cleared, and no done pulse is produced.

## Structure
- Package tile_pkg holds:
  - click_state encodings PAUSE/SCORE/MISS
  - colour-code encoding BG/TILE/HIT/MISS
  - the renderer state enum
  - default colour constants
- Sub-module tile_pixel_scan holds the px/py raster counter. Inputs: clear and enable. Outputs: px, py, last. tile_grid_renderer instantiates it once.

## Test plan
Bench parameters: TILE_W=4, TILE_H=2, COLS=4, ROWS=4.
- Reset, then start with grid=16'h0001, click_state=0 → 128 plot cycles. Tile (0,0) covers x 0-3, y 0-1 with colour 1ff; all other pixels are 05a. done arrives exactly 161 cycles after start, with busy high throughout.
- grid=16'h8000, click_state=2 → the tile at x 12-15, y 6-7 is 3a1. Repeat with click_state=1 → 3f2; with click_state=3 → 1ff.
- Full frame with grid=16'h00f0, then a second frame with dirty_only=1 and the same grid → zero plot cycles; done 33 cycles after start.
- Dirty frame changing only bit 5 → exactly 8 plots, all at x 4-7, y 2-3.
- Assert reset at the 50th plot, then start with dirty_only=1 → full 128-pixel redraw; no done pulse from the aborted frame.
- Pulse start during DRAW → ignored; frame length unchanged. Also check that changing grid mid-frame does not alter any plotted colour.
